// File: rtl/pcie_pixel_unpacker_pkg.sv
// Shared PCIe receive-side types and constants for the pixel unpacker.
package pcie_pixel_unpacker_pkg;

   localparam int unsigned PCIE_DATA_W = 128;
   localparam int unsigned SLOT_W      = 16;
   // Pixels per packet at the default 8-bit pixel width.
   localparam int unsigned PIX_PER_PKT = PCIE_DATA_W / 8;

   typedef struct packed {
      logic [2:0]             pad;
      logic [SLOT_W-1:0]      slot;
      logic                   last;
      logic                   valid;
      logic [PCIE_DATA_W-1:0] data;
   } pcie_packet_t;

endpackage

// File: rtl/pcie_pkt_fifo.sv
// Synchronous packet FIFO; a push at full is accepted when a pop happens in the same cycle.
module pcie_pkt_fifo
   import pcie_pixel_unpacker_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear,
   input  logic                   push,
   input  pcie_packet_t           wr_pkt,
   input  logic                   pop,
   output pcie_packet_t           head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   pcie_packet_t     mem [0:DEPTH-1];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_pop  = pop && !empty && !clear;
   assign do_push = push && !clear && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (!do_push && do_pop) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_pkt;
   end

endmodule

// File: rtl/pcie_pixel_unpacker.sv
// Buffers PCIe packet beats and serialises them into a valid/ready pixel stream.
module pcie_pixel_unpacker
   import pcie_pixel_unpacker_pkg::*;
#(
   parameter int unsigned PIX_W     = 8,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned AF_MARGIN = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  pcie_packet_t      pkt_in,
   output logic              almost_full,
   output logic              overflow,
   output logic [PIX_W-1:0]  pix_data,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic              pix_last,
   output logic [SLOT_W-1:0] pix_slot,
   output logic              frame_done
);

   localparam int unsigned PPP   = PCIE_DATA_W / PIX_W;
   localparam int unsigned IDX_W = (PPP > 1) ? $clog2(PPP) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(PPP - 1);
   localparam logic [CNT_W-1:0] AF_LEVEL = CNT_W'(DEPTH - AF_MARGIN);

   typedef enum logic {StIdle, StShift} state_e;

   state_e                 state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [PCIE_DATA_W-1:0] data_q;
   logic                   last_q;
   logic [SLOT_W-1:0]      slot_q;
   logic                   overflow_q, almost_full_q, frame_done_q;

   logic                   pop, handshake, dropped;
   logic                   fifo_full, fifo_empty;
   logic [CNT_W-1:0]       count;
   pcie_packet_t           head;
   logic                   unused_head;

   pcie_pkt_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (clear),
      .push   (pkt_in.valid),
      .wr_pkt (pkt_in),
      .pop    (pop),
      .head   (head),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .count  (count)
   );

   assign unused_head = ^{head.pad, head.valid};

   assign pix_valid   = (state_q == StShift);
   assign pix_data    = data_q[idx_q*PIX_W +: PIX_W];
   assign pix_last    = last_q && (idx_q == IDX_MAX);
   assign pix_slot    = slot_q;
   assign handshake   = pix_valid && pix_ready;
   assign dropped     = pkt_in.valid && fifo_full && !pop && !clear;
   assign overflow    = overflow_q;
   assign almost_full = almost_full_q;
   assign frame_done  = frame_done_q;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pop     = 1'b0;
      if (clear) begin
         state_d = StIdle;
         idx_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  idx_d   = '0;
                  state_d = StShift;
               end
            end
            StShift: begin
               if (handshake) begin
                  if (idx_q != IDX_MAX) begin
                     idx_d = idx_q + 1'b1;
                  end else if (!fifo_empty) begin
                     // Reload straight from the FIFO so back-to-back packets have no bubble.
                     pop   = 1'b1;
                     idx_d = '0;
                  end else begin
                     idx_d   = '0;
                     state_d = StIdle;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         idx_q         <= '0;
         data_q        <= '0;
         last_q        <= 1'b0;
         slot_q        <= '0;
         overflow_q    <= 1'b0;
         almost_full_q <= 1'b0;
         frame_done_q  <= 1'b0;
      end else if (clear) begin
         state_q       <= StIdle;
         idx_q         <= '0;
         data_q        <= '0;
         last_q        <= 1'b0;
         slot_q        <= '0;
         overflow_q    <= 1'b0;
         almost_full_q <= 1'b0;
         frame_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         if (pop) begin
            data_q <= head.data;
            last_q <= head.last;
            slot_q <= head.slot;
         end
         if (dropped) overflow_q <= 1'b1;
         almost_full_q <= (count >= AF_LEVEL);
         frame_done_q  <= handshake && pix_last;
      end
   end

endmodule

// File: tb/tb_pcie_pixel_unpacker.sv
// Directed self-checking bench for pcie_pixel_unpacker at default parameters.
module tb_pcie_pixel_unpacker;
   import pcie_pixel_unpacker_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n, clear, pix_ready;
   pcie_packet_t pkt_in;
   logic         almost_full, overflow, pix_valid, pix_last, frame_done;
   logic [7:0]   pix_data;
   logic [15:0]  pix_slot;

   int checks = 0;
   int errors = 0;

   pcie_pixel_unpacker #(
      .PIX_W     (8),
      .DEPTH     (4),
      .AF_MARGIN (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (clear),
      .pkt_in      (pkt_in),
      .almost_full (almost_full),
      .overflow    (overflow),
      .pix_data    (pix_data),
      .pix_valid   (pix_valid),
      .pix_ready   (pix_ready),
      .pix_last    (pix_last),
      .pix_slot    (pix_slot),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expected);
      checks++;
      if (got !== expected) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expected);
      end
   endtask

   function automatic pcie_packet_t mk(input logic [7:0] base, input logic last,
                                       input logic [15:0] slot);
      pcie_packet_t p;
      p = '0;
      for (int i = 0; i < PIX_PER_PKT; i++) p.data[i*8 +: 8] = base + 8'(i);
      p.valid = 1'b1;
      p.last  = last;
      p.slot  = slot;
      p.pad   = 3'b101;
      return p;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, pix_valid, 0);
      check({tag, "_last"}, pix_last, 0);
      check({tag, "_fdone"}, frame_done, 0);
      check({tag, "_af"}, almost_full, 0);
      check({tag, "_ovf"}, overflow, 0);
      check({tag, "_data"}, pix_data, 0);
      check({tag, "_slot"}, pix_slot, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int n, hs_a, hs_b, lasts, vcount, fd_count;
      bit found;

      rst_n = 1'b1; clear = 1'b0; pix_ready = 1'b0; pkt_in = '0;
      #1 rst_n = 1'b0;
      #2 check_all_zero("rst");
      repeat (2) tick();
      rst_n = 1'b1;
      tick();

      // Single packet, ready held high
      pix_ready = 1'b1;
      pkt_in = mk(8'h00, 1'b1, 16'h0005);
      tick();
      pkt_in = '0;
      check("t1_wait", pix_valid, 0);
      tick();
      for (int i = 0; i < 16; i++) begin
         check("t1_valid", pix_valid, 1);
         check("t1_data", pix_data, i);
         check("t1_slot", pix_slot, 16'h0005);
         check("t1_last", pix_last, (i == 15));
         check("t1_fdone_early", frame_done, 0);
         tick();
      end
      check("t1_fdone", frame_done, 1);
      check("t1_idle", pix_valid, 0);
      tick();
      check("t1_fdone_pulse", frame_done, 0);
      repeat (3) tick();

      // Three packets, one every 16 clocks
      vcount = 0;
      for (int c = 0; c < 52; c++) begin
         pkt_in = '0;
         if (c == 0 || c == 16 || c == 32) pkt_in = mk(8'(c), 1'b1, 16'(c / 16 + 1));
         tick();
         check("t2_valid", pix_valid, (c >= 1 && c <= 48));
         if (pix_valid) vcount++;
         if (c >= 1 && c <= 48) begin
            check("t2_data", pix_data, c - 1);
            check("t2_slot", pix_slot, (c - 1) / 16 + 1);
            check("t2_last", pix_last, ((c - 1) % 16 == 15));
         end
         check("t2_fdone", frame_done, (c >= 17 && c <= 49 && (c - 1) % 16 == 0));
      end
      pkt_in = '0;
      check("t2_count", vcount, 48);

      // Backpressure: ready 1,0,0,1
      n = 0; hs_a = 0; hs_b = 0; lasts = 0;
      for (int c = 0; c < 200 && n < 32; c++) begin
         pkt_in = '0;
         if (c == 0) pkt_in = mk(8'h40, 1'b1, 16'h0007);
         if (c == 1) pkt_in = mk(8'h50, 1'b1, 16'h0008);
         pix_ready = (c % 4 == 0) || (c % 4 == 3);
         if (pix_valid) begin
            check("t3_data", pix_data, 8'h40 + 8'(n));
            check("t3_slot", pix_slot, (n < 16) ? 16'h0007 : 16'h0008);
            check("t3_last", pix_last, (n % 16 == 15));
            if (pix_ready) begin
               if (n < 16) hs_a++;
               else hs_b++;
               if (pix_last) lasts++;
               n++;
            end
         end
         tick();
      end
      pkt_in = '0;
      pix_ready = 1'b1;
      check("t3_total", n, 32);
      check("t3_hs_a", hs_a, 16);
      check("t3_hs_b", hs_b, 16);
      check("t3_lasts", lasts, 2);
      repeat (3) tick();
      check("t3_idle", pix_valid, 0);

      // Burst of six beats with ready low
      pix_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         pkt_in = mk(8'(16 * c), 1'b1, 16'h0010 + 16'(c));
         tick();
         check("t4_af", almost_full, (c >= 3));
         check("t4_ovf", overflow, (c == 5));
      end
      pkt_in = '0;
      tick();
      check("t4_af_hold", almost_full, 1);
      n = 0;
      pix_ready = 1'b1;
      for (int c = 0; c < 300 && n < 80; c++) begin
         if (pix_valid) begin
            check("t4_data", pix_data, 8'(n));
            check("t4_slot", pix_slot, 16'h0010 + 16'(n / 16));
            n++;
         end
         tick();
      end
      check("t4_total", n, 80);
      repeat (2) tick();
      check("t4_no_sixth", pix_valid, 0);
      check("t4_ovf_sticky", overflow, 1);
      check("t4_af_drained", almost_full, 0);

      // clear at pixel index 7 with two packets queued
      pix_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         pkt_in = mk(8'(16 * c), 1'b1, 16'h0030 + 16'(c));
         tick();
      end
      pkt_in = '0;
      tick();
      check("t5_af", almost_full, 1);
      pix_ready = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 50 && !found; c++) begin
         if (pix_valid && pix_data == 8'h07) found = 1'b1;
         else tick();
      end
      check("t5_reach_idx7", found, 1);
      clear = 1'b1;
      pkt_in = mk(8'h60, 1'b1, 16'h003F);
      tick();
      clear = 1'b0;
      pkt_in = '0;
      check("t5_valid", pix_valid, 0);
      check("t5_af_clr", almost_full, 0);
      check("t5_ovf_clr", overflow, 0);
      vcount = 0; lasts = 0; fd_count = 0;
      for (int c = 0; c < 30; c++) begin
         if (pix_valid) vcount++;
         if (pix_last) lasts++;
         if (frame_done) fd_count++;
         tick();
      end
      check("t5_no_pixels", vcount, 0);
      check("t5_no_last", lasts, 0);
      check("t5_no_fdone", fd_count, 0);

      // Asynchronous reset mid-packet
      pix_ready = 1'b1;
      pkt_in = mk(8'h90, 1'b1, 16'h0044);
      tick();
      pkt_in = '0;
      repeat (5) tick();
      check("t6_pre_valid", pix_valid, 1);
      check("t6_pre_data", pix_data, 8'h94);
      #2 rst_n = 1'b0;
      #1 check_all_zero("t6_rst");
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      pkt_in = mk(8'hA0, 1'b1, 16'h0055);
      tick();
      pkt_in = '0;
      tick();
      for (int i = 0; i < 16; i++) begin
         check("t6_valid", pix_valid, 1);
         check("t6_data", pix_data, 8'hA0 + 8'(i));
         check("t6_slot", pix_slot, 16'h0055);
         check("t6_last", pix_last, (i == 15));
         tick();
      end
      check("t6_fdone", frame_done, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pcie_pixel_unpacker.md
Name: pcie_pixel_unpacker

Overview:
Sits directly downstream of the PCIe receive path and upstream of the sobel core. It consumes PCIEPacket beats (128-bit data, valid, last, 16-bit slot) and buffers them in a small packet FIFO. It serialises each packet into a pixel stream with valid/ready handshake, carrying the slot tag and end-of-frame marker. The PCIe side has no ready, so flow control is by an almost-full flag plus a sticky overflow error.

Parameters:
PIX_W, 8, pixel width in bits; must divide 128 exactly.
DEPTH, 4, packet FIFO depth in entries; power of two, at least 2.
AF_MARGIN, 2, almost_full asserts when occupancy >= DEPTH-AF_MARGIN.

Ports:
clk  in  1  single clock.
rst_n  in  1  reset, asynchronous assert, active-low.
clear  in  1  synchronous soft flush of FIFO, serialiser and overflow.
pkt_in  in  PCIEPacket (149 bits)  packet beat; accepted when pkt_in.valid=1.
almost_full  out  1  upstream throttle request.
overflow  out  1  sticky: a valid beat arrived while FIFO full.
pix_data  out  PIX_W  current pixel.
pix_valid  out  1  pixel valid.
pix_ready  in  1  sobel core ready.
pix_last  out  1  last pixel of frame (packet.last && final pixel index).
pix_slot  out  16  slot tag of the packet being emitted.
frame_done  out  1  one-cycle pulse on the pix_last handshake.

Behaviour:
- Reset (rst_n=0, async) clears all outputs to 0. FIFO is empty, state is IDLE and the pixel index is 0. pkt_in.pad is ignored.
- PPP = 128/PIX_W pixels per packet (16 at default). Pixel i = data[i*PIX_W +: PIX_W], LSB first.
- FIFO push: pkt_in.valid && (!full || pop_this_cycle). Full is computed from the registered count, so a push and a pop in the same cycle at full are both accepted and the count is unchanged.
- Push when full with no pop: the beat is dropped and overflow is set. Overflow clears only on reset or clear.
- almost_full is registered from count. It updates one cycle after a count change.
- Serialiser FSM:
  - IDLE: pix_valid=0. If the FIFO is non-empty, pop the head into the output register, set idx=0 and go to SHIFT. First pixel appears one cycle after the head exists.
  - SHIFT: pix_valid=1, and pix_data/pix_slot/pix_last are held stable while pix_ready=0.
  - SHIFT, handshake with idx<PPP-1: idx++.
  - SHIFT, handshake with idx==PPP-1, FIFO non-empty: pop next, idx=0, stay in SHIFT. No bubble.
  - SHIFT, handshake with idx==PPP-1, FIFO empty: go to IDLE.
- pix_last = reg.last && idx==PPP-1. frame_done pulses the cycle after the handshake that carries pix_last.
- Throughput: 1 pixel/clk with pix_ready held high. Input is sustainable at 1 packet per PPP clocks. Faster bursts absorb up to DEPTH packets plus the 1 in the output register.
- clear: in the next cycle the FIFO is empty, state is IDLE, idx=0, pix_valid=0, overflow=0, almost_full=0. A pkt_in beat arriving in the same cycle as clear is discarded. clear has priority over all other events.
- clear or reset mid-packet: the remaining pixels are discarded and no pix_last is emitted.
- Occupancy counter is log2(DEPTH)+1 bits. Read/write pointers wrap modulo DEPTH.

Decomposition:
- PCIEPacket, PCIE_DATA_W=128 and PIX_PER_PKT live in the shared PCIe package. Add PIX_PER_PKT as a localparam-style constant there.
- One natural sub-module: pcie_pkt_fifo, a DEPTH-entry synchronous PCIEPacket FIFO. It provides push/pop, full/empty, count and pass-through-on-full semantics.
- FSM, index counter and flags stay in the top block.

Test Plan:
- Single packet, data=0x0F0E..0100, last=1, slot=0x0005, pix_ready=1.
  - Expect pixels 0x00..0x0F on 16 consecutive cycles, slot 0x0005 on each.
  - Expect pix_last only on 0x0F, then frame_done one cycle later.
- Three back-to-back packets every 16 clocks with ready=1.
  - Expect 48 contiguous pix_valid cycles with no bubble.
  - Expect the slot to change exactly at packet boundaries.
- Backpressure: ready toggles 1,0,0,1 repeating.
  - Expect pix_data stable during low cycles.
  - Expect no pixel lost or duplicated, and 16 handshakes per packet.
- Burst of 6 valid beats on consecutive cycles with ready=0 (DEPTH=4).
  - Expect almost_full from occupancy 2.
  - Expect beats 1 (register) plus 4 (FIFO) kept, the 6th dropped and overflow=1.
  - On releasing ready, expect exactly 5*16 pixels.
- clear asserted at pixel idx 7 with 2 packets queued.
  - Next cycle expect pix_valid=0, almost_full=0 and overflow=0.
  - Expect no pix_last and no further pixels.
- rst_n pulsed low asynchronously mid-packet.
  - Expect all outputs at 0 immediately.
  - After release, a new packet streams from idx 0.
